// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state type, default width and width helpers for sqrt_iter_unit
package sqrt_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int root_w(input int width);
        return width / 2;
    endfunction

    function automatic int rem_w(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring square-root step (one root bit per call)
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [rem_w(WIDTH)-1:0]  rem_p,
    input  logic [root_w(WIDTH)-1:0] root_p,
    input  logic [1:0]               bits,
    output logic [rem_w(WIDTH)-1:0]  rem_next,
    output logic                     root_bit
);

    localparam int ROOT_W = root_w(WIDTH);
    localparam int REM_W  = rem_w(WIDTH);
    localparam int T_W    = ROOT_W + 3;

    logic [T_W-1:0]   sum_in;
    logic [T_W-1:0]   sub;
    logic [REM_W-1:0] diff;
    logic             t_nonneg;

    assign sum_in = {rem_p, bits};
    assign sub    = {1'b0, root_p, 2'b01};

    // The sign of t is taken from a full-width compare; the difference itself
    // always fits in REM_W bits because rem never exceeds twice the partial root.
    assign t_nonneg = (sum_in >= sub);
    assign diff     = sum_in[REM_W-1:0] - sub[REM_W-1:0];

    always_comb begin
        if (t_nonneg) begin
            rem_next = diff;
            root_bit = 1'b1;
        end else begin
            rem_next = sum_in[REM_W-1:0];
            root_bit = 1'b0;
        end
    end

endmodule

// File: rtl/sqrt_iter_unit.sv
// rtl/sqrt_iter_unit.sv - iterative integer square root, one bit per clock; SQRT_ROUND_EN selects rounded root
module sqrt_iter_unit
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem
);

    localparam int N     = root_w(WIDTH);
    localparam int REM_W = rem_w(WIDTH);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [REM_W-1:0] rem_p;
    logic [REM_W-1:0] rem_step;
    logic [N-1:0]     root_p;
    logic [N-1:0]     root_step;
    logic [N-1:0]     root_final;
    logic             root_bit;
    logic [CNT_W-1:0] cnt;

    sqrt_step #(.WIDTH(WIDTH)) u_step (
        .rem_p    (rem_p),
        .root_p   (root_p),
        .bits     (shreg[WIDTH-1 -: 2]),
        .rem_next (rem_step),
        .root_bit (root_bit)
    );

    assign root_step = {root_p[N-2:0], root_bit};

    // Rounding is decided from the final step's remainder, so it adds no cycle.
    always_comb begin
        root_final = root_step;
`ifdef SQRT_ROUND_EN
        if ((rem_step > {1'b0, root_step}) && (root_step != '1)) begin
            root_final = root_step + N'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            shreg  <= '0;
            rem_p  <= '0;
            root_p <= '0;
            cnt    <= '0;
            root   <= '0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg  <= radicand;
                        rem_p  <= '0;
                        root_p <= '0;
                        cnt    <= CNT_W'(N - 1);
                    end
                end
                CALC: begin
                    shreg  <= {shreg[WIDTH-3:0], 2'b00};
                    rem_p  <= rem_step;
                    root_p <= root_step;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        root <= root_final;
                        rem  <= rem_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: doc/sqrt_iter_unit.md
# sqrt_iter_unit

Iterative integer square-root unit: takes an unsigned radicand from the upstream register stage, computes the floor square root and remainder one result bit per clock, and signals completion with a single-cycle `done` pulse. It sits between the enable-gated operand register bank and the result consumer. It replaces a purely combinational root array with a small, shared, sequential datapath.

## Interface
- `WIDTH`, default 16: radicand width in bits. Must be even and ≥ 4. `N = WIDTH/2` is the root width.
- `clk`  in  1: sole clock, rising edge.
- `clr`  in  1: reset, synchronous, active-low. Sampled on the rising edge of `clk`.
- `start`  in  1: request to begin a computation. Accepted only in IDLE.
- `radicand`  in  WIDTH: unsigned operand. Sampled on the accepting edge only.
- `busy`  out  1: high while a computation is in progress (CALC state).
- `done`  out  1: one-cycle pulse marking the cycle in which the result first becomes valid.
- `root`  out  N: floor(sqrt(radicand)), or the rounded root when `SQRT_ROUND_EN` is defined.
- `rem`  out  N+1: radicand − floor_root², where 0 ≤ rem ≤ 2·floor_root.

## Operation
- **States:**
  - IDLE: waits for `start`.
  - CALC: iterates `N` times.
  - DONE: lasts one cycle, then returns to IDLE.
- **Reset:** while `clr` is 0 at a rising edge, the unit enters IDLE with `busy`=0, `done`=0, `root`=0, `rem`=0, and the internal shift register and counter cleared. Reset takes effect from any state, including mid-CALC. A computation in progress is discarded and no `done` is produced.
- **IDLE → CALC:** occurs on an edge with `start`=1. On that edge the unit loads `radicand` into the shift register, sets the partial remainder and partial root to 0, and sets the counter to N−1.
- **CALC step (one per edge):**
  - Form the trial value t = {rem_p, top 2 bits of shift register} − {root_p, 2'b01}, with width N+3.
  - If t ≥ 0: rem_p ← t and root_p ← {root_p, 1}.
  - Otherwise: rem_p ← {rem_p, top 2 bits} and root_p ← {root_p, 0}.
  - The shift register shifts left by 2 in both cases.
- **CALC → DONE:** occurs on the step taken when the counter is 0. The `root` and `rem` output registers are updated on that same edge.
- **DONE:** `done`=1 for exactly one cycle, then the unit returns to IDLE unconditionally.
- **Output hold:** `root` and `rem` hold their values from DONE until the next DONE or the next reset. They do not change during a subsequent CALC.
- **start outside IDLE:** `start` in CALC or DONE is ignored and is not queued. A `start` held high continuously re-triggers on the first IDLE edge after DONE.
- **Arithmetic:** all arithmetic is unsigned apart from the sign check on t. No overflow is possible at the stated widths.

## Timing
- Call the accepting edge E0.
- `busy` = 1 from after E0 through the N-th CALC edge, i.e. for N cycles.
- `done` = 1 in the cycle following edge E0+N.
- Latency from start to result: N+1 edges. For WIDTH=16 this is 9 edges.
- Throughput: one result per N+2 cycles with `start` held high.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- The macro is `SQRT_ROUND_EN`.
- **Defined:** `root` is rounded to nearest. The root is incremented if and only if the final rem > floor_root. If the floor root is all-ones, the result saturates at all-ones instead of incrementing. The comparison is evaluated combinationally on the final CALC edge, so latency is unchanged. `rem` still reports the floor-root remainder.
- **Undefined:** `root` is the floor root and the rounding logic is absent.

## Structure
- **Package `sqrt_pkg`:** contains
  - the state enum (IDLE, CALC, DONE);
  - the default WIDTH constant;
  - the derived `ROOT_W`/`REM_W` width functions.
- **Sub-module `sqrt_step`:** purely combinational. Inputs are rem_p, root_p and the next 2 radicand bits. Outputs are the next rem_p and the next root bit. The top level holds the FSM, counter, shift register and output registers.

## Test plan
- WIDTH=16, reset, radicand=144, start pulse → `done` at edge E0+9, `root`=12, `rem`=0, `busy` high for exactly 8 cycles.
- radicand=150 → `root`=12, `rem`=6. radicand=0 → `root`=0, `rem`=0. radicand=65535 → `root`=255, `rem`=510.
- `start` re-pulsed during CALC with radicand=9 → ignored. The original 150 computation completes with `root`=12, `rem`=6, and exactly one `done` occurs.
- `clr`=0 at the 4th CALC edge → next cycle state is IDLE, outputs are all 0, and no `done` occurs. A new start with 49 → `root`=7, `rem`=0.
- `start` held high with radicand=25 → `done` pulses every 10 cycles, and `root`=5 stays stable between pulses.
- With `SQRT_ROUND_EN` defined: 156 → `root`=12 (rem=12, not > 12); 157 → `root`=13 (`rem`=13); 65535 → `root`=255 (saturated, `rem`=510).
